// File: rtl/stage_sequencer.sv
// Stage sequencer: runs a multi-stage game through play, between-stage
// result screen and win/lose end states, and keeps score and money.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for the first startPulse after reset
// PLAY   | stage block enabled, points accepted, waiting for stageEnded
// RESULT | between-stage result screen, counting down whole seconds
// WON    | last stage passed, totals frozen until startPulse
// LOST   | a stage failed, totals frozen until startPulse
module stage_sequencer #(
  parameter int          NUM_LEVELS     = 4,
  parameter int          RESULT_SECONDS = 3,
  parameter logic [19:0] SCORE_MAX      = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startPulse,
  input  logic        oneSecPulse,
  input  logic        stageEnded,
  input  logic        stagePassed,
  input  logic [19:0] scoreIncrease,
  output logic        levelEnable,
  output logic        cycleLevel,
  output logic [3:0]  levelIndex,
  output logic [19:0] score,
  output logic [19:0] money,
  output logic [7:0]  resultCountdown,
  output logic [2:0]  gameState
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLAY   = 3'd1,
    RESULT = 3'd2,
    WON    = 3'd3,
    LOST   = 3'd4
  } stateT;

  localparam logic [3:0] LAST_LEVEL  = 4'(NUM_LEVELS - 1);
  localparam logic [7:0] RESULT_LOAD = 8'(RESULT_SECONDS);

  stateT       state, stateNext;
  logic [3:0]  levelNext;
  logic [19:0] scoreNext, moneyNext;
  logic [7:0]  countNext;
  logic        cycleNext;
  logic [20:0] scoreSum, moneySum;

  // Clamp a 21-bit sum to the ceiling so totals never wrap.
  function automatic logic [19:0] saturate(input logic [20:0] sum);
    if (sum > {1'b0, SCORE_MAX}) return SCORE_MAX;
    return sum[19:0];
  endfunction

  assign scoreSum  = {1'b0, score} + {1'b0, scoreIncrease};
  assign moneySum  = {1'b0, money} + {1'b0, scoreIncrease};
  assign gameState = state;

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      levelEnable     <= 1'b0;
      cycleLevel      <= 1'b0;
      levelIndex      <= 4'd0;
      score           <= 20'd0;
      money           <= 20'd0;
      resultCountdown <= 8'd0;
    end else begin
      state           <= stateNext;
      levelEnable     <= (stateNext == PLAY);
      cycleLevel      <= cycleNext;
      levelIndex      <= levelNext;
      score           <= scoreNext;
      money           <= moneyNext;
      resultCountdown <= countNext;
    end
  end

  // Next-state and next-output decode; everything holds unless a state acts.
  always_comb begin
    stateNext = state;
    levelNext = levelIndex;
    scoreNext = score;
    moneyNext = money;
    countNext = resultCountdown;
    cycleNext = 1'b0;
    case (state)
      IDLE, WON, LOST: begin
        if (startPulse) begin
          stateNext = PLAY;
          levelNext = 4'd0;
          scoreNext = 20'd0;
          moneyNext = 20'd0;
          countNext = 8'd0;
        end
      end
      PLAY: begin
        // Points in the stageEnded cycle still count.
        scoreNext = saturate(scoreSum);
        moneyNext = saturate(moneySum);
        if (stageEnded) begin
          if (!stagePassed) begin
            stateNext = LOST;
          end else if (levelIndex >= LAST_LEVEL) begin
            stateNext = WON;
          end else begin
            stateNext = RESULT;
            countNext = RESULT_LOAD;
          end
        end
      end
      RESULT: begin
        // startPulse and the final second share one exit path, so both
        // together still advance the level only once.
        if (startPulse || (oneSecPulse && resultCountdown <= 8'd1)) begin
          stateNext = PLAY;
          countNext = 8'd0;
          cycleNext = 1'b1;
          if (levelIndex < LAST_LEVEL) levelNext = levelIndex + 4'd1;
        end else if (oneSecPulse) begin
          countNext = resultCountdown - 8'd1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer with NUM_LEVELS=2, RESULT_SECONDS=3.
module tb_stage_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startPulse = 1'b0;
  logic        oneSecPulse = 1'b0;
  logic        stageEnded = 1'b0;
  logic        stagePassed = 1'b0;
  logic [19:0] scoreIncrease = 20'd0;
  logic        levelEnable;
  logic        cycleLevel;
  logic [3:0]  levelIndex;
  logic [19:0] score;
  logic [19:0] money;
  logic [7:0]  resultCountdown;
  logic [2:0]  gameState;

  int errors = 0;
  int checks = 0;

  stage_sequencer #(.NUM_LEVELS(2), .RESULT_SECONDS(3), .SCORE_MAX(20'hFFFFF)) dut (
    .clk(clk),
    .reset(reset),
    .startPulse(startPulse),
    .oneSecPulse(oneSecPulse),
    .stageEnded(stageEnded),
    .stagePassed(stagePassed),
    .scoreIncrease(scoreIncrease),
    .levelEnable(levelEnable),
    .cycleLevel(cycleLevel),
    .levelIndex(levelIndex),
    .score(score),
    .money(money),
    .resultCountdown(resultCountdown),
    .gameState(gameState)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs set before the call are sampled at the edge, then
  // one-cycle pulses are released and outputs settle for checking.
  task automatic tick();
    @(posedge clk);
    #1;
    startPulse    = 1'b0;
    oneSecPulse   = 1'b0;
    stageEnded    = 1'b0;
    stagePassed   = 1'b0;
    scoreIncrease = 20'd0;
  endtask

  task automatic checkAllReset(input string tag);
    check({tag, "_state"}, gameState, 0);
    check({tag, "_en"}, levelEnable, 0);
    check({tag, "_cyc"}, cycleLevel, 0);
    check({tag, "_lvl"}, levelIndex, 0);
    check({tag, "_score"}, score, 0);
    check({tag, "_money"}, money, 0);
    check({tag, "_cd"}, resultCountdown, 0);
  endtask

  initial begin
    #3;
    checkAllReset("rst0");
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("idle_wait", gameState, 0);

    // Ignored in IDLE
    stageEnded = 1'b1; stagePassed = 1'b1; scoreIncrease = 20'd77;
    tick();
    check("idle_ign_state", gameState, 0);
    check("idle_ign_score", score, 0);

    // Start game
    startPulse = 1'b1;
    tick();
    check("start_state", gameState, 1);
    check("start_en", levelEnable, 1);
    check("start_lvl", levelIndex, 0);

    scoreIncrease = 20'd100;
    tick();
    check("add100_score", score, 100);
    check("add100_money", money, 100);

    startPulse = 1'b1;
    tick();
    check("play_start_ign", gameState, 1);
    stagePassed = 1'b1;
    tick();
    check("passed_alone_ign", gameState, 1);

    // Pass with simultaneous points
    stageEnded = 1'b1; stagePassed = 1'b1; scoreIncrease = 20'd50;
    tick();
    check("pass0_state", gameState, 2);
    check("pass0_en", levelEnable, 0);
    check("pass0_cd", resultCountdown, 3);
    check("pass0_score", score, 150);

    scoreIncrease = 20'd200;
    tick();
    check("result_ign_score", score, 150);
    check("result_ign_money", money, 150);

    oneSecPulse = 1'b1;
    tick();
    check("cd2", resultCountdown, 2);
    check("cd2_cyc", cycleLevel, 0);
    oneSecPulse = 1'b1;
    tick();
    check("cd1", resultCountdown, 1);
    oneSecPulse = 1'b1;
    tick();
    check("exit_cd", resultCountdown, 0);
    check("exit_lvl", levelIndex, 1);
    check("exit_cyc", cycleLevel, 1);
    check("exit_state", gameState, 1);
    check("exit_en", levelEnable, 1);
    tick();
    check("exit_cyc_drop", cycleLevel, 0);

    // Pass last level -> WON
    stageEnded = 1'b1; stagePassed = 1'b1;
    tick();
    check("won_state", gameState, 3);
    check("won_score", score, 150);
    check("won_money", money, 150);
    check("won_en", levelEnable, 0);
    check("won_lvl", levelIndex, 1);
    oneSecPulse = 1'b1;
    tick();
    check("won_cyc", cycleLevel, 0);

    // Restart from WON, then saturation
    startPulse = 1'b1;
    tick();
    check("restart_state", gameState, 1);
    check("restart_score", score, 0);
    check("restart_lvl", levelIndex, 0);
    scoreIncrease = 20'hFFF00;
    tick();
    check("sat_pre", score, 20'hFFF00);
    scoreIncrease = 20'h00200;
    tick();
    check("sat_score", score, 20'hFFFFF);
    check("sat_money", money, 20'hFFFFF);
    stageEnded = 1'b1; stagePassed = 1'b1;
    tick();
    check("sat_result", gameState, 2);
    scoreIncrease = 20'h00200;
    tick();
    check("sat_result_score", score, 20'hFFFFF);
    check("sat_result_money", money, 20'hFFFFF);

    // oneSec + start together in RESULT
    oneSecPulse = 1'b1;
    tick();
    check("sim_cd2", resultCountdown, 2);
    oneSecPulse = 1'b1; startPulse = 1'b1;
    tick();
    check("sim_lvl", levelIndex, 1);
    check("sim_cyc", cycleLevel, 1);
    check("sim_cd", resultCountdown, 0);
    check("sim_state", gameState, 1);
    tick();
    check("sim_lvl_hold", levelIndex, 1);
    check("sim_cyc_drop", cycleLevel, 0);

    // Fail at level 1, restart, fail at level 0
    stageEnded = 1'b1; stagePassed = 1'b0;
    tick();
    check("lost1_state", gameState, 4);
    check("lost1_score", score, 20'hFFFFF);
    startPulse = 1'b1;
    tick();
    check("restart2_lvl", levelIndex, 0);
    stageEnded = 1'b1; stagePassed = 1'b0;
    tick();
    check("lost0_state", gameState, 4);
    check("lost0_en", levelEnable, 0);
    check("lost0_cyc", cycleLevel, 0);
    stageEnded = 1'b1; stagePassed = 1'b1;
    tick();
    check("lost_stage_ign", gameState, 4);

    // Reset mid-RESULT at countdown 2
    startPulse = 1'b1;
    tick();
    scoreIncrease = 20'd5;
    tick();
    stageEnded = 1'b1; stagePassed = 1'b1;
    tick();
    oneSecPulse = 1'b1;
    tick();
    check("prerst_cd", resultCountdown, 2);
    check("prerst_score", score, 5);
    #1 reset = 1'b1;
    #1;
    checkAllReset("rstmid");
    @(posedge clk);
    #1;
    check("rst_hold_cyc", cycleLevel, 0);
    reset = 1'b0;
    tick();
    check("postrst_idle", gameState, 0);
    startPulse = 1'b1;
    tick();
    check("postrst_state", gameState, 1);
    check("postrst_lvl", levelIndex, 0);
    check("postrst_score", score, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
